// File: rtl/playback_sequencer.sv
// Tracker playback sequencer: debounced play/pause button, stop/rewind, and a
// tick prescaler that steps through the lines of a phrase at a programmable speed.
module playback_sequencer #(
    parameter int TICK_DIV        = 250000,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int NUM_LINES       = 16
) (
    input  logic                         clk,
    input  logic                         rst_active_low,
    input  logic                         play_button,
    input  logic                         stop_req,
    input  logic [3:0]                   ticks_per_line,
    output logic [$clog2(NUM_LINES)-1:0] line_count,
    output logic                         line_strobe,
    output logic                         tick_strobe,
    output logic                         phrase_wrap,
    output logic                         playing,
    output logic [1:0]                   state_dbg
);

    localparam int LW = $clog2(NUM_LINES);
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [LW-1:0] LINE_LAST  = LW'(NUM_LINES - 1);
    localparam logic [DW-1:0] DEB_FULL   = DW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        ST_STOPPED = 2'd0,
        ST_PLAYING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_e;

    logic          sync1_q, sync2_q, last_q;
    logic [1:0]    fill_q;
    logic [DW-1:0] run_q, run_d;
    logic          sample_valid, stable;
    logic          accepted_q, armed_q, press_q;

    // The two samples that leave the synchronizer right after reset are the
    // flops' reset value, not the pin, so the debouncer ignores them.
    assign sample_valid = fill_q[1];

    always_comb begin
        run_d = DW'(1);
        if (!sample_valid) begin
            run_d = '0;
        end else if (sync2_q == last_q) begin
            run_d = (run_q == DEB_FULL) ? run_q : run_q + DW'(1);
        end
    end

    assign stable = sample_valid && (run_d == DEB_FULL);

    // A press needs a debounced low first, so a button held through reset
    // release never counts as a press.
    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            last_q     <= 1'b0;
            fill_q     <= 2'b00;
            run_q      <= '0;
            accepted_q <= 1'b0;
            armed_q    <= 1'b0;
            press_q    <= 1'b0;
        end else begin
            sync1_q <= play_button;
            sync2_q <= sync1_q;
            last_q  <= sync2_q;
            fill_q  <= {fill_q[0], 1'b1};
            run_q   <= run_d;
            press_q <= stable && sync2_q && !accepted_q && armed_q;
            if (stable) begin
                accepted_q <= sync2_q;
                if (!sync2_q) begin
                    armed_q <= 1'b1;
                end
            end
        end
    end

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    tick_in_line_q, eff_tpl_q, tpl_clamped;

    assign tpl_clamped = (ticks_per_line == 4'd0) ? 4'd1 : ticks_per_line;
    assign state_dbg   = state_q;

    always_ff @(posedge clk or negedge rst_active_low) begin
        if (!rst_active_low) begin
            state_q        <= ST_STOPPED;
            presc_q        <= '0;
            tick_in_line_q <= '0;
            eff_tpl_q      <= 4'd1;
            line_count     <= '0;
            line_strobe    <= 1'b0;
            tick_strobe    <= 1'b0;
            phrase_wrap    <= 1'b0;
            playing        <= 1'b0;
        end else begin
            line_strobe <= 1'b0;
            tick_strobe <= 1'b0;
            phrase_wrap <= 1'b0;
            if (stop_req) begin
                state_q        <= ST_STOPPED;
                presc_q        <= '0;
                tick_in_line_q <= '0;
                line_count     <= '0;
                playing        <= 1'b0;
            end else if (press_q) begin
                case (state_q)
                    ST_STOPPED: begin
                        state_q        <= ST_PLAYING;
                        playing        <= 1'b1;
                        line_count     <= '0;
                        line_strobe    <= 1'b1;
                        presc_q        <= '0;
                        tick_in_line_q <= '0;
                        eff_tpl_q      <= tpl_clamped;
                    end
                    ST_PLAYING: begin
                        state_q <= ST_PAUSED;
                        playing <= 1'b0;
                    end
                    default: begin
                        state_q <= ST_PLAYING;
                        playing <= 1'b1;
                    end
                endcase
            end else if (state_q == ST_PLAYING) begin
                if (presc_q == PRESC_LAST) begin
                    presc_q     <= '0;
                    tick_strobe <= 1'b1;
                    if (tick_in_line_q == eff_tpl_q - 4'd1) begin
                        // Line boundary: new speed is picked up only here.
                        tick_in_line_q <= '0;
                        line_strobe    <= 1'b1;
                        eff_tpl_q      <= tpl_clamped;
                        if (line_count == LINE_LAST) begin
                            line_count  <= '0;
                            phrase_wrap <= 1'b1;
                        end else begin
                            line_count <= line_count + LW'(1);
                        end
                    end else begin
                        tick_in_line_q <= tick_in_line_q + 4'd1;
                    end
                end else begin
                    presc_q <= presc_q + PW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_playback_sequencer.sv
// Bench for playback_sequencer: directed scenarios plus random button/stop/speed
// traffic, checked every cycle against a line-timing model of the sequencer.
module tb_playback_sequencer;

    localparam int TD  = 4;
    localparam int DEB = 3;
    localparam int NL  = 16;

    logic       clk            = 1'b0;
    logic       rst_active_low = 1'b0;
    logic       play_button    = 1'b0;
    logic       stop_req       = 1'b0;
    logic [3:0] ticks_per_line = 4'd2;
    logic [3:0] line_count;
    logic       line_strobe, tick_strobe, phrase_wrap, playing;
    logic [1:0] state_dbg;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [3:0] tpl_v      = 4'd2;
    logic       m_in_reset = 1'b1;

    playback_sequencer #(
        .TICK_DIV        (TD),
        .DEBOUNCE_CYCLES (DEB),
        .NUM_LINES       (NL)
    ) dut (
        .clk            (clk),
        .rst_active_low (rst_active_low),
        .play_button    (play_button),
        .stop_req       (stop_req),
        .ticks_per_line (ticks_per_line),
        .line_count     (line_count),
        .line_strobe    (line_strobe),
        .tick_strobe    (tick_strobe),
        .phrase_wrap    (phrase_wrap),
        .playing        (playing),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    // reference model: button history window + cycles elapsed within the current line
    logic m_btn_hist[$];
    logic m_samp[$];
    logic m_acc, m_armed, m_press_pend;
    int   m_state;  // 0 stopped, 1 playing, 2 paused
    int   m_run, m_eff, m_line;
    logic [7:0] m_exp;

    task automatic model_reset();
        m_btn_hist.delete();
        m_samp.delete();
        m_acc        = 1'b0;
        m_armed      = 1'b0;
        m_press_pend = 1'b0;
        m_state      = 0;
        m_run        = 0;
        m_eff        = 1;
        m_line       = 0;
    endtask

    task automatic model_step(input logic b, input logic s, input int tpl);
        int   n;
        logic smp, stab, press, ls, ts, pw;
        n    = m_btn_hist.size();
        smp  = 1'b0;
        stab = 1'b0;
        if (n >= 2) begin
            smp = m_btn_hist[n-2];
            m_samp.push_back(smp);
            stab = (m_samp.size() >= DEB);
            for (int i = 1; i <= DEB; i++) begin
                if (stab && m_samp[m_samp.size()-i] != smp) stab = 1'b0;
            end
        end
        m_btn_hist.push_back(b);
        press        = m_press_pend;
        m_press_pend = stab && smp && !m_acc && m_armed;
        if (stab) begin
            m_acc = smp;
            if (!smp) m_armed = 1'b1;
        end
        ls = 1'b0; ts = 1'b0; pw = 1'b0;
        if (s) begin
            m_state = 0; m_run = 0; m_line = 0;
        end else if (press) begin
            if (m_state == 0) begin
                m_state = 1; m_line = 0; ls = 1'b1; m_run = 0;
                m_eff = (tpl == 0) ? 1 : tpl;
            end else if (m_state == 1) begin
                m_state = 2;
            end else begin
                m_state = 1;
            end
        end else if (m_state == 1) begin
            m_run++;
            ts = (m_run % TD == 0);
            if (m_run == m_eff * TD) begin
                m_run  = 0;
                ls     = 1'b1;
                pw     = (m_line == NL - 1);
                m_line = (m_line + 1) % NL;
                m_eff  = (tpl == 0) ? 1 : tpl;
            end
        end
        m_exp = {m_state == 1, ls, ts, pw, 4'(m_line)};
    endtask

    // driver tasks
    task automatic cycle(input logic b, input logic s);
        play_button    = b;
        stop_req       = s;
        ticks_per_line = tpl_v;
        if (m_in_reset) begin
            exp_q.push_back(8'h00);
        end else begin
            model_step(b, s, int'(tpl_v));
            exp_q.push_back(m_exp);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int outs();
        return int'({playing, line_strobe, tick_strobe, phrase_wrap, line_count});
    endfunction

    task automatic run_count(input logic b, input int ncyc,
                             output int n_ts, output int n_ls, output int n_pw);
        n_ts = 0; n_ls = 0; n_pw = 0;
        for (int i = 0; i < ncyc; i++) begin
            cycle(b, 1'b0);
            n_ts += int'(tick_strobe);
            n_ls += int'(line_strobe);
            n_pw += int'(phrase_wrap);
        end
    endtask

    task automatic press_until_strobe(output int n);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0);
            if (n == 0 && line_strobe) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_line(input int target, output int ok);
        ok = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'b0);
            if (line_strobe && int'(line_count) == target) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic assert_reset(input logic b, input int hold);
        rst_active_low = 1'b0;
        #1;
        check("reset_immediate", outs(), 0);
        model_reset();
        m_in_reset = 1'b1;
        repeat (hold) cycle(b, 1'b0);
        rst_active_low = 1'b1;
        m_in_reset     = 1'b0;
    endtask

    // scoreboard: one expected output vector per clock edge
    initial begin : compare
        logic [7:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {playing, line_strobe, tick_strobe, phrase_wrap, line_count};
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs @%0t: got play=%b ls=%b ts=%b pw=%b line=%0d, expected play=%b ls=%b ts=%b pw=%b line=%0d",
                             $time, a[7], a[6], a[5], a[4], a[3:0], e[7], e[6], e[5], e[4], e[3:0]);
                end
            end
        end
    end

    initial begin : driver
        int   n, a, b, c, held_line, ok, hold;
        logic lvl;
        model_reset();
        m_in_reset = 1'b1;
        repeat (3) cycle(1'b0, 1'b0);
        check("reset_outputs", outs(), 0);
        rst_active_low = 1'b1;
        m_in_reset     = 1'b0;
        repeat (10) cycle(1'b0, 1'b0);

        // clean press, then a whole phrase at 2 ticks per line
        press_until_strobe(n);
        check("press_latency", n, 6);
        check("start_line", int'(line_count), 0);
        check("start_playing", int'(playing), 1);
        run_count(1'b0, 128, a, b, c);
        check("ticks_in_phrase", a, 32);
        check("lines_in_phrase", b, 16);
        check("wraps_in_phrase", c, 1);
        check("wrap_cycle", int'({line_strobe, phrase_wrap, line_count}), 6'b110000);

        cycle(1'b0, 1'b1);
        check("stop_outputs", outs(), 0);
        repeat (6) cycle(1'b0, 1'b0);

        // bouncy press: high 1, low 1, high 2, then stable high
        cycle(1'b1, 1'b0); cycle(1'b0, 1'b0); cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
        press_until_strobe(n);
        check("bouncy_latency", n, 4);
        run_count(1'b1, 30, a, b, c);
        check("bouncy_single_press", int'(playing), 1);
        repeat (10) cycle(1'b0, 1'b0);

        // pause, hold frozen, resume
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0);
            if (!playing) begin n = i; break; end
        end
        check("pause_latency", n, 6);
        held_line = int'(line_count);
        run_count(1'b0, 100, a, b, c);
        check("pause_ticks", a, 0);
        check("pause_lines", b, 0);
        check("pause_frozen_line", int'(line_count), held_line);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b1, 1'b0);
            if (playing) begin n = i; break; end
        end
        check("resume_latency", n, 6);
        check("resume_no_strobe", int'(line_strobe), 0);

        // stop and press land together at line 5
        wait_line(5, ok);
        check("reach_line5", ok, 1);
        n = 0;
        while (!m_press_pend && n < 20) begin
            cycle(1'b1, 1'b0);
            n++;
        end
        cycle(1'b1, 1'b1);
        check("stop_beats_press", outs(), 0);
        run_count(1'b0, 20, a, b, c);
        check("stop_stays_stopped", int'(playing) + a + b, 0);

        // speed change 2 -> 0 in the middle of a line
        press_until_strobe(n);
        check("restart_latency", n, 6);
        repeat (5) cycle(1'b0, 1'b0);
        tpl_v = 4'd0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cycle(1'b0, 1'b0);
            if (line_strobe) begin n = i; break; end
        end
        check("tpl_old_line_len", n, 3);
        run_count(1'b0, 40, a, b, c);
        check("tpl0_ticks", a, 10);
        check("tpl0_lines", b, 10);

        // reset at line 7 with the button held high across release
        tpl_v = 4'd2;
        wait_line(7, ok);
        check("reach_line7", ok, 1);
        cycle(1'b1, 1'b0);
        assert_reset(1'b1, 3);
        run_count(1'b1, 40, a, b, c);
        check("held_through_reset_no_play", int'(playing) + b, 0);
        repeat (10) cycle(1'b0, 1'b0);
        press_until_strobe(n);
        check("fresh_press_latency", n, 6);

        // random traffic
        for (int k = 0; k < 3000; ) begin
            hold = int'($urandom_range(1, 8));
            lvl  = 1'($urandom_range(0, 1));
            for (int j = 0; j < hold; j++) begin
                if ($urandom_range(0, 49) == 0) tpl_v = 4'($urandom_range(0, 4));
                cycle(lvl, $urandom_range(0, 149) == 0);
                k++;
            end
            if ($urandom_range(0, 399) == 0) assert_reset(lvl, 2);
        end
        repeat (2) cycle(1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/playback_sequencer.md
PLAYBACK_SEQUENCER -- requirements
Module: playback_sequencer

Interface
REQ-001 SHALL have parameter TICK_DIV, default 250000, meaning clk cycles per tracker tick (48 Hz at 12 MHz); legal range >= 2.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 120000, meaning consecutive stable synchronized samples required to accept a button level; legal range >= 1.
REQ-003 SHALL have parameter NUM_LINES, default 16, meaning lines per phrase; line_count width is clog2(NUM_LINES).
REQ-004 clk  input  1  single clock for all logic.
REQ-005 rst_active_low  input  1  reset, asynchronous assert, active-low.
REQ-006 play_button  input  1  raw asynchronous pause/play button, active-high.
REQ-007 stop_req  input  1  one-cycle pulse; stop playback and rewind to line 0.
REQ-008 ticks_per_line  input  4  speed: ticks per line; value 0 is treated as 1.
REQ-009 line_count  output  4  current phrase row, driven to PhraseData row and playback line index.
REQ-010 line_strobe  output  1  one-cycle pulse; line_count holds a newly entered line.
REQ-011 tick_strobe  output  1  one-cycle pulse per tracker tick while playing.
REQ-012 phrase_wrap  output  1  one-cycle pulse coincident with line_strobe when line_count wraps NUM_LINES-1 -> 0.
REQ-013 playing  output  1  high only in state PLAYING.

Function
REQ-014 play_button SHALL pass through a 2-flop synchronizer, then a debouncer accepting a new level only after DEBOUNCE_CYCLES consecutive identical synchronized samples; press = accepted level 0->1 (one-cycle internal pulse); release generates no event.
REQ-015 FSM states SHALL be STOPPED, PLAYING, PAUSED.
REQ-016 press in STOPPED -> PLAYING; the next cycle SHALL have line_count=0, line_strobe=1, prescaler=0, tick-in-line=0.
REQ-017 press in PLAYING -> PAUSED; prescaler, tick-in-line and line_count SHALL freeze, with no strobes while paused.
REQ-018 press in PAUSED -> PLAYING; counting SHALL resume from frozen values with no line_strobe on resume.
REQ-019 stop_req in any state -> STOPPED next cycle, with line_count=0, all counters cleared, no strobes; stop_req SHALL win over a simultaneous press.
REQ-020 In PLAYING, the prescaler SHALL count 0..TICK_DIV-1 and wrap; tick_strobe SHALL be high in the cycle after the prescaler equals TICK_DIV-1.
REQ-021 On each tick, tick-in-line SHALL increment; when it equals eff_tpl-1 (eff_tpl = max(ticks_per_line,1)), it SHALL clear and line_count SHALL advance, asserting line_strobe in the same cycle as tick_strobe and the new line_count.
REQ-022 line_count SHALL wrap NUM_LINES-1 -> 0 with phrase_wrap=1 in that line_strobe cycle.
REQ-023 ticks_per_line SHALL be sampled into eff_tpl only at line_strobe and at STOPPED->PLAYING; mid-line changes SHALL take effect on the next line.
REQ-024 All outputs SHALL be registered; strobes SHALL never exceed one cycle.

Reset
REQ-025 While rst_active_low=0: state=STOPPED, line_count=0, line_strobe=0, tick_strobe=0, phrase_wrap=0, playing=0, all counters 0, synchronizer and debouncer accepted level=0.
REQ-026 Reset mid-operation SHALL abort immediately (asynchronously); after deassertion the block SHALL be in STOPPED and SHALL require a fresh press to play.
REQ-027 A button held high through reset release SHALL NOT generate a press; a press requires release then press.

Verification (TICK_DIV=4, DEBOUNCE_CYCLES=3, NUM_LINES=16, ticks_per_line=2)
REQ-028 Reset, then clean press -> playing=1 and line_strobe with line_count=0; tick_strobe every 4 cycles; line_strobe every 8 cycles; line_count 0,1,2,...
REQ-029 Run to line 15, then the next line boundary -> line_count=0, line_strobe=1, phrase_wrap=1 in the same cycle; phrase_wrap=0 on all other lines.
REQ-030 Bouncy button (high 1 cycle, low 1, high 2, then stable high) -> exactly one press event; second clean press -> PAUSED with line_count frozen for 100 cycles; third press resumes with the next tick spaced correctly relative to the frozen prescaler.
REQ-031 stop_req asserted in the same cycle as a debounced press while PLAYING at line 5 -> STOPPED, line_count=0, playing=0, no strobes.
REQ-032 ticks_per_line changed 2->0 mid-line -> current line keeps 2 ticks; subsequent lines last 1 tick (line_strobe on every tick_strobe).
REQ-033 Reset asserted mid-line at line 7 with button held high -> outputs immediately at reset values; after release with button still high, no playback until release-then-press.
